// File: rtl/rr_output_arbiter_pkg.sv
// Shared definitions for the per-output round-robin arbiter: port ordering,
// port count, index type and arbiter state encoding.
package rr_output_arbiter_pkg;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_IDX_W = $clog2(NUM_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_output_arbiter_pick.sv
// Combinational round-robin pick: first requester after `last` in circular
// order, found by scanning {req, req & above_last} from the low end.
module rr_priority_pick #(
  parameter int N  = 5,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          any,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx
);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic           w_found;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (32'(i) > 32'(last));
    end
    w_dbl = {req, req & w_mask};
  end

  // Lower half holds requesters above `last`; upper half wraps to the rest.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    w_found  = 1'b0;
    for (int j = 0; j < 2*N; j++) begin
      if (any && !w_found && w_dbl[j]) begin
        w_found = 1'b1;
        if (j < N) begin
          pick[j]  = 1'b1;
          pick_idx = IW'(j);
        end else begin
          pick[j-N] = 1'b1;
          pick_idx  = IW'(j - N);
        end
      end
    end
  end

endmodule

// File: rtl/rr_output_arbiter.sv
// Per-output round-robin arbiter: registered one-hot grant held until the
// valid/ready transfer, then re-arbitrated in the same cycle with no bubble.
import rr_output_arbiter_pkg::*;

module rr_output_arbiter #(
  parameter int NUM_PORTS   = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         req,
  input  logic                         out_ready,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         out_valid,
  output logic [NUM_PORTS-1:0]         in_ready,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic [NUM_PORTS-1:0]    r_grant;
  logic [IW-1:0]           r_grant_idx;
  logic [IW-1:0]           r_last;
  logic [STALL_CNT_W-1:0]  r_stall_cnt;

  logic [NUM_PORTS-1:0]    w_grant_nxt;
  logic [IW-1:0]           w_grant_idx_nxt;
  logic [IW-1:0]           w_last_nxt;
  logic [STALL_CNT_W-1:0]  w_stall_nxt;

  logic                    w_g_req;
  logic                    w_transfer;
  logic                    w_stall;
  logic [IW-1:0]           w_pick_last;
  logic                    w_pick_any;
  logic [NUM_PORTS-1:0]    w_pick;
  logic [IW-1:0]           w_pick_idx;

  assign w_g_req     = |(r_grant & req);
  assign w_transfer  = (r_state == ST_GRANTED) && w_g_req && out_ready;
  assign w_stall     = (r_state == ST_GRANTED) && w_g_req && !out_ready;
  // On a transfer the search restarts just after the winner being retired.
  assign w_pick_last = (r_state == ST_GRANTED) ? r_grant_idx : r_last;
  assign w_pick_any  = (r_state == ST_IDLE) || w_transfer;

  rr_priority_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .req      (req),
    .last     (w_pick_last),
    .any      (w_pick_any),
    .pick     (w_pick),
    .pick_idx (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = (|req) ? ST_GRANTED : ST_IDLE;
      end
      ST_GRANTED: begin
        if (w_transfer) begin
          w_state_nxt = (|req) ? ST_GRANTED : ST_IDLE;
        end else if (w_stall) begin
          w_state_nxt = ST_GRANTED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_last_nxt      = r_last;
    w_stall_nxt     = r_stall_cnt;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt     = w_pick;
        w_grant_idx_nxt = w_pick_idx;
      end
      ST_GRANTED: begin
        if (w_transfer) begin
          w_last_nxt      = r_grant_idx;
          w_grant_nxt     = w_pick;
          w_grant_idx_nxt = w_pick_idx;
        end else if (w_stall) begin
          if (r_stall_cnt != {STALL_CNT_W{1'b1}}) begin
            w_stall_nxt = r_stall_cnt + STALL_CNT_W'(1);
          end else begin
            w_stall_nxt = r_stall_cnt;
          end
        end else begin
          w_grant_nxt     = '0;
          w_grant_idx_nxt = '0;
        end
      end
      default: begin
        w_grant_nxt     = '0;
        w_grant_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_last      <= IW'(NUM_PORTS - 1);
      r_stall_cnt <= '0;
    end else begin
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_last      <= w_last_nxt;
      r_stall_cnt <= w_stall_nxt;
    end
  end

  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign stall_cnt = r_stall_cnt;
  assign out_valid = |(r_grant & req);
  assign in_ready  = r_grant & {NUM_PORTS{out_ready}};

endmodule

// File: tb/tb_rr_output_arbiter.sv
// Scoreboard bench: driver steps a circular-search reference model and queues
// expected outputs; a monitor checks the DUT one delta after every rising edge.
module tb_rr_output_arbiter;

  localparam int NP   = 5;
  localparam int SMAX = 65535;

  typedef struct packed {
    logic [4:0]  grant;
    logic [2:0]  idx;
    logic        valid;
    logic [4:0]  in_rdy;
    logic [15:0] stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = 5'd0;
  logic        out_ready = 1'b0;
  logic [4:0]  grant;
  logic [2:0]  grant_idx;
  logic        out_valid;
  logic [4:0]  in_ready;
  logic [15:0] stall_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  int m_gnt   = -1;
  int m_last  = NP - 1;
  int m_stall = 0;

  rr_output_arbiter #(.NUM_PORTS(NP), .STALL_CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int search(input int from, input logic [4:0] r);
    for (int k = 1; k <= NP; k++) begin
      int i;
      i = (from + k) % NP;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Reference: grant holds until transfer, then next requester after winner.
  task automatic model_step(input logic [4:0] r, input logic rdy, input logic rs);
    exp_t e;
    if (rs) begin
      m_gnt = -1; m_last = NP - 1; m_stall = 0;
    end else if (m_gnt < 0) begin
      if (r != 5'd0) m_gnt = search(m_last, r);
    end else if (r[m_gnt]) begin
      if (rdy) begin
        m_last = m_gnt;
        m_gnt  = search(m_gnt, r);
      end else if (m_stall < SMAX) begin
        m_stall++;
      end
    end else begin
      m_gnt = -1;
    end
    e.grant  = (m_gnt >= 0) ? 5'(1 << m_gnt) : 5'd0;
    e.idx    = (m_gnt >= 0) ? 3'(m_gnt) : 3'd0;
    e.valid  = (m_gnt >= 0) && r[m_gnt];
    e.in_rdy = rdy ? e.grant : 5'd0;
    e.stall  = 16'(m_stall);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] r, input logic rdy, input logic rs);
    req = r; out_ready = rdy; rst = rs;
    model_step(r, rdy, rs);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_grant",     32'(grant),     32'(mon_e.grant));
      chk("sb_grant_idx", 32'(grant_idx), 32'(mon_e.idx));
      chk("sb_out_valid", 32'(out_valid), 32'(mon_e.valid));
      chk("sb_in_ready",  32'(in_ready),  32'(mon_e.in_rdy));
      chk("sb_stall_cnt", 32'(stall_cnt), 32'(mon_e.stall));
    end
  end

  initial begin
    logic [4:0] r;
    logic       rdy;
    logic       rs;
    @(negedge clk);

    // Reset held with all requesting, then NORTH wins first.
    for (int i = 0; i < 3; i++) drive(5'b11111, 1'b1, 1'b1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    drive(5'b11111, 1'b0, 1'b0);
    chk("first_grant", 32'(grant), 32'h01);
    chk("first_idx", 32'(grant_idx), 32'd0);

    // Full contention, one transfer per cycle.
    drive(5'b11111, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(5'b11111, 1'b1, 1'b0);
      chk("rr_seq_idx", 32'(grant_idx), 32'(k % NP));
      chk("rr_seq_valid", 32'(out_valid), 32'd1);
    end

    // SOUTH stalls 7 cycles, transfers, then withdraws.
    drive(5'b00000, 1'b0, 1'b1);
    drive(5'b00100, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) drive(5'b00100, 1'b0, 1'b0);
    chk("stall7_grant", 32'(grant), 32'h04);
    chk("stall7_cnt", 32'(stall_cnt), 32'd7);
    drive(5'b00100, 1'b1, 1'b0);
    drive(5'b00000, 1'b1, 1'b0);
    chk("stall7_idle", 32'(grant), 32'd0);
    chk("stall7_hold", 32'(stall_cnt), 32'd7);

    // WEST withdraws; LOCAL granted after one idle cycle.
    drive(5'b00000, 1'b0, 1'b1);
    drive(5'b01000, 1'b0, 1'b0);
    chk("wd_west", 32'(grant), 32'h08);
    drive(5'b10000, 1'b1, 1'b0);
    chk("wd_bubble", 32'(grant), 32'd0);
    drive(5'b10000, 1'b1, 1'b0);
    chk("wd_local", 32'(grant), 32'h10);

    // Back-to-back: WEST, then LOCAL ahead of newly joined NORTH.
    drive(5'b00000, 1'b0, 1'b1);
    drive(5'b11000, 1'b0, 1'b0);
    chk("b2b_west", 32'(grant), 32'h08);
    drive(5'b11001, 1'b1, 1'b0);
    chk("b2b_local", 32'(grant), 32'h10);
    chk("b2b_local_idx", 32'(grant_idx), 32'd4);
    drive(5'b10001, 1'b1, 1'b0);
    chk("b2b_north", 32'(grant), 32'h01);

    // Stall counter saturation, then reset mid-stall.
    drive(5'b00000, 1'b0, 1'b1);
    for (int k = 0; k < 65536 + 5; k++) drive(5'b00100, 1'b0, 1'b0);
    chk("sat_cnt", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat_grant", 32'(grant), 32'h04);
    drive(5'b00100, 1'b0, 1'b1);
    chk("sat_rst_grant", 32'(grant), 32'd0);
    chk("sat_rst_cnt", 32'(stall_cnt), 32'd0);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      r   = 5'($urandom_range(0, 31));
      rdy = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 63) == 0);
      drive(r, rdy, rs);
    end

    @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_output_arbiter.md
# rr_output_arbiter

Per-output-port round-robin arbiter for the `router_x_y` crossbar. One instance sits in front of each of the five output ports (NORTH, EAST, SOUTH, WEST, LOCAL). It takes route-matched requests from the input ports and issues a registered one-hot grant plus crossbar select. It holds the grant until the downstream `valid`/`ready` transfer completes, then rotates priority.

## Interface
Parameters:
- `NUM_PORTS`, default 5: number of requesting input ports; index order NORTH..LOCAL from `global_params`.
- `STALL_CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  NUM_PORTS: `req[i]` high when input `i` holds a valid flit routed to this output.
- `out_ready`  in  1: `ready` from the downstream router or local sink on this output.
- `grant`  out  NUM_PORTS: one-hot registered grant, or all-zero.
- `grant_idx`  out  $clog2(NUM_PORTS): crossbar select; equals the index of the set bit in `grant`, 0 when idle.
- `out_valid`  out  1: `|(grant & req)`; drives output-port `valid`.
- `in_ready`  out  NUM_PORTS: `grant & {NUM_PORTS{out_ready}}`; drives input-port `ready` toward the arbiter.
- `stall_cnt`  out  STALL_CNT_W: saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Two states:
  - IDLE: `grant` is 0.
  - GRANTED: `grant` is one-hot.
- Priority pointer `last[ ]`: index of the most recent winner. Search order is `last+1, last+2, …` with modulo-NUM_PORTS wrap. `last` is NUM_PORTS-1 after reset, so index 0 (NORTH) has first priority.
- IDLE: if `|req`, register the grant for the first requester in search order and go to GRANTED. Otherwise stay in IDLE.
- GRANTED with granted index `g`:
  - Transfer (`req[g] && out_ready`):
    - Set `last <= g`.
    - Re-arbitrate in the same cycle over `req` using search order from `g+1`.
    - If any requester exists, load the new grant and stay in GRANTED. This gives back-to-back transfers with no bubble.
    - Otherwise go to IDLE.
  - Stall (`req[g] && !out_ready`): hold the grant unchanged. Increment `stall_cnt` and saturate at all-ones.
  - Withdrawal (`!req[g]`): go to IDLE with `grant` cleared. `last` is unchanged and no transfer is counted.
- Requester `g` still asserting `req` at its own transfer cycle competes at lowest priority. If it is the only requester it is re-granted. If its `req` then drops, the withdrawal rule costs one idle cycle.
- Combinational outputs (`out_valid`, `in_ready`) depend only on registered `grant` and current inputs. There is no `req`→`grant` combinational path.

## Timing
- Reset (sync, `rst`=1 at a rising edge) forces:
  - `grant`=0, `grant_idx`=0, `out_valid`=0, `in_ready`=0, `stall_cnt`=0.
  - `last`=NUM_PORTS-1, state IDLE.
  - Reset mid-transfer drops the grant at that edge. Any flit not yet accepted remains with its requester.
- Grant latency from IDLE: `req` sampled at edge t, `grant` valid after edge t, first possible transfer in cycle t+1.
- Sustained throughput is 1 transfer/cycle while any requester stays asserted and `out_ready`=1.
- Fairness: with all NUM_PORTS requesting continuously, each port is served exactly once every NUM_PORTS transfers.
- `stall_cnt` does not wrap. It is cleared only by `rst`.

## Structure
- `global_params` holds:
  - the port enum (NORTH, EAST, SOUTH, WEST, LOCAL);
  - `NUM_PORTS`;
  - a `port_idx_t` typedef of width $clog2(NUM_PORTS).
- Sub-module `rr_priority_pick`: purely combinational. Takes `req`, `last` and `any`, and returns a one-hot pick plus its index. It uses the mask/double-width rotate technique and is shared by the IDLE and transfer paths.
- `router_x_y` instantiates 5× `rr_output_arbiter`. The `req` vectors come from the XY route compute.

## Test plan
- Reset with `req`=5'b11111 held → all outputs 0 during reset; first grant after release is 5'b00001 (NORTH), `grant_idx`=0.
- `req`=5'b11111 and `out_ready`=1 for 10 cycles → grant sequence N,E,S,W,L,N,E,S,W,L with one transfer per cycle and no bubble.
- `req`=5'b00100, `out_ready`=0 for 7 cycles, then 1 → grant stays at 5'b00100, `stall_cnt`=7, one transfer, then IDLE.
- Granted WEST (`g`=3), WEST drops `req` before a transfer, LOCAL requesting → one cycle with `grant`=0, then `grant`=5'b10000. `last` stays at the prior value, so `grant` shows no skew.
- `out_ready`=0 with SOUTH granted for 2^16+5 cycles → `stall_cnt` saturates at 16'hFFFF; assert `rst` mid-stall → `grant`=0 and `stall_cnt`=0 on the next cycle.
- Back-to-back contention: WEST and LOCAL request, WEST wins, then NORTH joins at WEST's transfer cycle → next grant is LOCAL (index 4), then NORTH.
